// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control decoder with a multi-cycle MUL/UDIV sequencer
//
// Ports:
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   valid_in, flush  issue strobe for AluOp/insOp; abort of any in-flight op
//   AluOp, insOp     main-control ALU class and R-type opcode field (instr[31:21])
//   ready_out        combinational: block is idle and will accept valid_in
//   AluOpCode        registered ALU operation code (holds when code_valid=0)
//   code_valid       AluOpCode valid: 1-cycle pulse, or held for a whole multi-cycle op
//   busy, done       multi-cycle op in progress; pulse on its last busy cycle
//   illegal          1-cycle pulse for an unrecognised R-type opcode
module alu_control_seq #(
  parameter int OPCODE_W      = 11,
  parameter int ALUCODE_W     = 4,
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 flush,
  input  logic [1:0]           AluOp,
  input  logic [OPCODE_W-1:0]  insOp,
  output logic                 ready_out,
  output logic [ALUCODE_W-1:0] AluOpCode,
  output logic                 code_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [0:0] {S_IDLE, S_MULTI} state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(11'b10001011000);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(11'b11001011000);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(11'b10001010000);
  localparam logic [OPCODE_W-1:0] OP_ORR  = OPCODE_W'(11'b10101010000);
  localparam logic [OPCODE_W-1:0] OP_LSL  = OPCODE_W'(11'b11010011011);
  localparam logic [OPCODE_W-1:0] OP_LSR  = OPCODE_W'(11'b11010011010);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(11'b10011011000);
  localparam logic [OPCODE_W-1:0] OP_UDIV = OPCODE_W'(11'b10011010110);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ALUCODE_W-1:0] code_q, code_d;
  logic                 code_valid_q, code_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;

  logic [3:0]           dec_code;
  logic                 dec_multi;
  logic                 dec_illegal;

  // Pure decode of the current inputs; AluOp[0] (CBZ pass-B) outranks AluOp[1].
  always_comb begin
    dec_code    = 4'b0010;
    dec_multi   = 1'b0;
    dec_illegal = 1'b0;
    if (AluOp[0]) begin
      dec_code = 4'b0111;
    end else if (AluOp[1]) begin
      case (insOp)
        OP_ADD:  dec_code = 4'b0010;
        OP_SUB:  dec_code = 4'b0110;
        OP_AND:  dec_code = 4'b0000;
        OP_ORR:  dec_code = 4'b0001;
        OP_LSL:  dec_code = 4'b0011;
        OP_LSR:  dec_code = 4'b0100;
        OP_MUL:  begin dec_code = 4'b1000; dec_multi = 1'b1; end
        OP_UDIV: begin dec_code = 4'b1001; dec_multi = 1'b1; end
        default: begin dec_code = 4'b1111; dec_illegal = 1'b1; end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in && !flush) begin
          code_d = ALUCODE_W'(dec_code);
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else begin
            code_valid_d = 1'b1;
            if (dec_multi) begin
              state_d = S_MULTI;
              cnt_d   = CNT_LOAD;
              busy_d  = 1'b1;
            end
          end
        end
      end
      S_MULTI: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          // done is registered, so raising it while cnt_q==1 makes it
          // visible in the cycle the counter reads 0 (the last busy cycle).
          cnt_d        = cnt_q - CNT_W'(1);
          busy_d       = 1'b1;
          code_valid_d = 1'b1;
          done_d       = (cnt_q == CNT_W'(1));
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ready_out  = (state_q == S_IDLE);
  assign AluOpCode  = code_q;
  assign code_valid = code_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - self-checking bench for alu_control_seq
module tb_alu_control_seq;

  localparam logic [10:0] I_ADD  = 11'b10001011000;
  localparam logic [10:0] I_SUB  = 11'b11001011000;
  localparam logic [10:0] I_AND  = 11'b10001010000;
  localparam logic [10:0] I_ORR  = 11'b10101010000;
  localparam logic [10:0] I_LSL  = 11'b11010011011;
  localparam logic [10:0] I_LSR  = 11'b11010011010;
  localparam logic [10:0] I_MUL  = 11'b10011011000;
  localparam logic [10:0] I_UDIV = 11'b10011010110;
  localparam logic [10:0] I_BAD  = 11'b11111111111;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, flush;
  logic [1:0]  AluOp;
  logic [10:0] insOp;
  logic        ready_out, code_valid, busy, done, illegal;
  logic [3:0]  AluOpCode;

  int n_checks = 0;
  int n_fail   = 0;

  alu_control_seq dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
    .AluOp(AluOp), .insOp(insOp), .ready_out(ready_out),
    .AluOpCode(AluOpCode), .code_valid(code_valid), .busy(busy),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        fl;
    logic [1:0]  aluop;
    logic [10:0] ins;
    logic [3:0]  exp_code;
    logic        exp_cv;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] ins);
    valid_in = v;
    AluOp    = op;
    insOp    = ins;
  endtask

  // Issues a multi-cycle op and leaves the bench in busy cycle 1.
  task automatic issue(input logic [10:0] ins);
    drive(1'b1, 2'b10, ins);
    tick();
    drive(1'b0, 2'b00, 11'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_code"}, 32'(AluOpCode), 32'h0);
    chk({tag, "_cv"}, 32'(code_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_ill"}, 32'(illegal), 32'h0);
    chk({tag, "_ready"}, 32'(ready_out), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 2'b10, I_ADD);

    vecs.push_back('{"ldur_add",  1'b1, 1'b0, 2'b00, I_SUB,  4'b0010, 1'b1, 1'b0});
    vecs.push_back('{"idle_hold", 1'b0, 1'b0, 2'b00, I_SUB,  4'b0010, 1'b0, 1'b0});
    vecs.push_back('{"add",       1'b1, 1'b0, 2'b10, I_ADD,  4'b0010, 1'b1, 1'b0});
    vecs.push_back('{"sub",       1'b1, 1'b0, 2'b10, I_SUB,  4'b0110, 1'b1, 1'b0});
    vecs.push_back('{"and",       1'b1, 1'b0, 2'b10, I_AND,  4'b0000, 1'b1, 1'b0});
    vecs.push_back('{"orr",       1'b1, 1'b0, 2'b10, I_ORR,  4'b0001, 1'b1, 1'b0});
    vecs.push_back('{"lsl",       1'b1, 1'b0, 2'b10, I_LSL,  4'b0011, 1'b1, 1'b0});
    vecs.push_back('{"lsr",       1'b1, 1'b0, 2'b10, I_LSR,  4'b0100, 1'b1, 1'b0});
    vecs.push_back('{"cbz_prio",  1'b1, 1'b0, 2'b11, I_SUB,  4'b0111, 1'b1, 1'b0});
    vecs.push_back('{"cbz",       1'b1, 1'b0, 2'b01, I_ADD,  4'b0111, 1'b1, 1'b0});
    vecs.push_back('{"illegal",   1'b1, 1'b0, 2'b10, I_BAD,  4'b1111, 1'b0, 1'b1});
    vecs.push_back('{"ill_hold",  1'b0, 1'b0, 2'b10, I_BAD,  4'b1111, 1'b0, 1'b0});
    vecs.push_back('{"flush_idl", 1'b1, 1'b1, 2'b10, I_ADD,  4'b1111, 1'b0, 1'b0});
    vecs.push_back('{"flush_ill", 1'b1, 1'b1, 2'b10, I_BAD,  4'b1111, 1'b0, 1'b0});
    vecs.push_back('{"add2",      1'b1, 1'b0, 2'b10, I_ADD,  4'b0010, 1'b1, 1'b0});

    // Reset held for two edges, with a valid op presented to prove reset wins.
    tick();
    tick();
    chk_idle_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      chk({vecs[i].name, "_ready_pre"}, 32'(ready_out), 32'h1);
      drive(vecs[i].valid, vecs[i].aluop, vecs[i].ins);
      flush = vecs[i].fl;
      tick();
      flush = 1'b0;
      chk({vecs[i].name, "_code"}, 32'(AluOpCode), 32'(vecs[i].exp_code));
      chk({vecs[i].name, "_cv"}, 32'(code_valid), 32'(vecs[i].exp_cv));
      chk({vecs[i].name, "_ill"}, 32'(illegal), 32'(vecs[i].exp_ill));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'h0);
      chk({vecs[i].name, "_done"}, 32'(done), 32'h0);
    end
    drive(1'b0, 2'b00, 11'd0);
    tick();

    // MUL: 8 busy cycles, done only in the 8th; an ADD held from cycle 2 is ignored.
    issue(I_MUL);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("mul_busy_c%0d", c), 32'(busy), 32'h1);
      chk($sformatf("mul_ready_c%0d", c), 32'(ready_out), 32'h0);
      chk($sformatf("mul_code_c%0d", c), 32'(AluOpCode), 32'h8);
      chk($sformatf("mul_cv_c%0d", c), 32'(code_valid), 32'h1);
      chk($sformatf("mul_done_c%0d", c), 32'(done), 32'(c == 8));
      if (c == 2) drive(1'b1, 2'b10, I_ADD);
      tick();
    end
    chk("mul_end_busy", 32'(busy), 32'h0);
    chk("mul_end_cv", 32'(code_valid), 32'h0);
    chk("mul_end_done", 32'(done), 32'h0);
    chk("mul_end_ready", 32'(ready_out), 32'h1);
    chk("mul_end_code_hold", 32'(AluOpCode), 32'h8);
    tick();
    drive(1'b0, 2'b00, 11'd0);
    chk("readd_code", 32'(AluOpCode), 32'h2);
    chk("readd_cv", 32'(code_valid), 32'h1);
    tick();

    // UDIV flushed in busy cycle 3.
    issue(I_UDIV);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("udiv_busy_c%0d", c), 32'(busy), 32'h1);
      chk($sformatf("udiv_code_c%0d", c), 32'(AluOpCode), 32'h9);
      if (c == 3) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    chk("udiv_fl_busy", 32'(busy), 32'h0);
    chk("udiv_fl_cv", 32'(code_valid), 32'h0);
    chk("udiv_fl_done", 32'(done), 32'h0);
    chk("udiv_fl_ready", 32'(ready_out), 32'h1);
    tick();
    chk("udiv_fl_done2", 32'(done), 32'h0);

    // MUL flushed in busy cycle 7, the cycle that would raise done.
    issue(I_MUL);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("mulf_done_c%0d", c), 32'(done), 32'h0);
      if (c == 7) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    chk("mulf_done", 32'(done), 32'h0);
    chk("mulf_busy", 32'(busy), 32'h0);
    chk("mulf_ready", 32'(ready_out), 32'h1);
    tick();
    chk("mulf_done2", 32'(done), 32'h0);

    // Reset in busy cycle 5 of MUL, then a normal ADD.
    issue(I_MUL);
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) rst_n = 1'b0;
      tick();
    end
    chk_idle_zero("mulrst");
    rst_n = 1'b1;
    drive(1'b1, 2'b10, I_ADD);
    tick();
    drive(1'b0, 2'b00, 11'd0);
    chk("mulrst_add_code", 32'(AluOpCode), 32'h2);
    chk("mulrst_add_cv", 32'(code_valid), 32'h1);
    chk("mulrst_add_busy", 32'(busy), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
